// File: rtl/idct_pkg.sv
// Shared state encoding, default widths and accumulator sizing for the 8x8 inverse-DCT engine.
package idct_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WAIT,
        ST_ACCUM,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int COEF_W_DEF      = 12;
    localparam int BASIS_W_DEF     = 16;
    localparam int FRAC_DEF        = 14;
    localparam int PIX_W_DEF       = 8;
    localparam int LEVEL_SHIFT_DEF = 128;

    // Six guard bits hold the sum of 64 full-scale products without overflow.
    function automatic int acc_width(input int coef_w, input int basis_w);
        return coef_w + basis_w + 6;
    endfunction

endpackage

// File: rtl/pixel_round_sat.sv
// Rounds the fixed-point accumulator to an integer, applies the level shift and clamps to pixel range.
module pixel_round_sat #(
    parameter int ACC_W       = 34,
    parameter int FRAC        = 14,
    parameter int PIX_W       = 8,
    parameter int LEVEL_SHIFT = 128
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [PIX_W-1:0] pix
);

    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (FRAC - 1);
    localparam logic signed [ACC_W:0] LVL     = (ACC_W+1)'(LEVEL_SHIFT);
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << PIX_W) - 1);

    // One extra bit so the rounding add can never wrap.
    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] leveled;

    assign acc_ext = {acc[ACC_W-1], acc};
    assign rounded = acc_ext + HALF;
    assign shifted = rounded >>> FRAC;
    assign leveled = shifted + LVL;

    always_comb begin
        pix = '0;
        if (leveled < 0) begin
            pix = '0;
        end else if (leveled > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = leveled[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/idct_8x8_engine.sv
// Inverse-DCT sequencer: walks 64 pixels x 64 coefficients, accumulating F(u,v)*B(x,y,u,v) per pixel.
module idct_8x8_engine
    import idct_pkg::*;
#(
    parameter int COEF_W      = COEF_W_DEF,
    parameter int BASIS_W     = BASIS_W_DEF,
    parameter int FRAC        = FRAC_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int LEVEL_SHIFT = LEVEL_SHIFT_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    output logic [5:0]                Coef_Addr,
    output logic [11:0]               Basis_Addr,
    output logic                      Read_Enable,
    input  logic signed [COEF_W-1:0]  Coef_Data,
    input  logic signed [BASIS_W-1:0] Basis_Data,
    output logic [5:0]                Pixel_Addr,
    output logic [PIX_W-1:0]          Pixel_Data,
    output logic                      Pixel_Valid,
    output logic                      Busy,
    output logic                      Ready
);

    localparam int ACC_W  = acc_width(COEF_W, BASIS_W);
    localparam int PROD_W = COEF_W + BASIS_W;

    state_t                   state_reg;
    logic [2:0]               u_reg, v_reg, x_reg, y_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     read_enable_reg;
    logic                     pixel_valid_reg;
    logic                     busy_reg;
    logic                     ready_reg;
    logic [5:0]               pixel_addr_reg;
    logic [PIX_W-1:0]         pixel_data_reg;

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_next;
    logic [PIX_W-1:0]         pix_rounded;
    logic [5:0]               uv_next;
    logic [5:0]               xy_next;
    logic                     last_term;
    logic                     last_pixel;

    assign product    = PROD_W'(Coef_Data) * PROD_W'(Basis_Data);
    assign acc_next   = acc_reg + ACC_W'(product);
    assign uv_next    = {u_reg, v_reg} + 6'd1;
    assign xy_next    = {x_reg, y_reg} + 6'd1;
    assign last_term  = (u_reg == 3'd7) && (v_reg == 3'd7);
    assign last_pixel = (x_reg == 3'd7) && (y_reg == 3'd7);

    // The pixel is formed from the sum including the final term, so it can be captured entering WRITE.
    pixel_round_sat #(
        .ACC_W       (ACC_W),
        .FRAC        (FRAC),
        .PIX_W       (PIX_W),
        .LEVEL_SHIFT (LEVEL_SHIFT)
    ) u_round (
        .acc (acc_next),
        .pix (pix_rounded)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg       <= ST_IDLE;
            u_reg           <= '0;
            v_reg           <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            acc_reg         <= '0;
            read_enable_reg <= 1'b0;
            pixel_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            ready_reg       <= 1'b0;
            pixel_addr_reg  <= '0;
            pixel_data_reg  <= '0;
        end else begin
            read_enable_reg <= 1'b0;
            pixel_valid_reg <= 1'b0;
            ready_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        state_reg <= ST_ADDR;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    state_reg       <= ST_READ;
                    read_enable_reg <= 1'b1;
                end
                ST_READ: state_reg <= ST_WAIT;
                ST_WAIT: state_reg <= ST_ACCUM;
                ST_ACCUM: begin
                    acc_reg        <= acc_next;
                    {u_reg, v_reg} <= uv_next;
                    if (last_term) begin
                        state_reg       <= ST_WRITE;
                        pixel_valid_reg <= 1'b1;
                        pixel_data_reg  <= pix_rounded;
                        pixel_addr_reg  <= {x_reg, y_reg};
                    end else begin
                        state_reg <= ST_ADDR;
                    end
                end
                ST_WRITE: begin
                    acc_reg        <= '0;
                    {x_reg, y_reg} <= xy_next;
                    u_reg          <= '0;
                    v_reg          <= '0;
                    if (last_pixel) begin
                        state_reg <= ST_DONE;
                        ready_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign Coef_Addr   = {u_reg, v_reg};
    assign Basis_Addr  = {x_reg, y_reg, u_reg, v_reg};
    assign Read_Enable = read_enable_reg;
    assign Pixel_Addr  = pixel_addr_reg;
    assign Pixel_Data  = pixel_data_reg;
    assign Pixel_Valid = pixel_valid_reg;
    assign Busy        = busy_reg;
    assign Ready       = ready_reg;

endmodule

// File: tb/tb_idct_8x8_engine.sv
// Directed bench for idct_8x8_engine with behavioural coefficient RAM / basis ROM and a pixel scoreboard.
module tb_idct_8x8_engine;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Start;
    logic [5:0]         Coef_Addr;
    logic [11:0]        Basis_Addr;
    logic               Read_Enable;
    logic signed [11:0] Coef_Data;
    logic signed [15:0] Basis_Data;
    logic [5:0]         Pixel_Addr;
    logic [7:0]         Pixel_Data;
    logic               Pixel_Valid;
    logic               Busy;
    logic               Ready;

    idct_8x8_engine dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Coef_Addr   (Coef_Addr),
        .Basis_Addr  (Basis_Addr),
        .Read_Enable (Read_Enable),
        .Coef_Data   (Coef_Data),
        .Basis_Data  (Basis_Data),
        .Pixel_Addr  (Pixel_Addr),
        .Pixel_Data  (Pixel_Data),
        .Pixel_Valid (Pixel_Valid),
        .Busy        (Busy),
        .Ready       (Ready)
    );

    always #5 Clock = ~Clock;

    // Memories with two-cycle read latency
    logic signed [11:0] coef_mem  [64];
    logic signed [15:0] basis_mem [4096];
    logic signed [11:0] c1, c2;
    logic signed [15:0] b1, b2;

    always @(posedge Clock) begin
        if (Read_Enable) begin
            c1 <= coef_mem[Coef_Addr];
            b1 <= basis_mem[Basis_Addr];
        end
        c2 <= c1;
        b2 <= b1;
    end
    assign Coef_Data  = c2;
    assign Basis_Data = b2;

    int edge_cnt = 0;
    always @(posedge Clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
        int         at_edge;
    } exp_t;

    exp_t sb[$];
    int   rq[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   re_cnt   = 0;
    int   s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pix(input int p);
        longint sum = 0;
        for (int k = 0; k < 64; k++) begin
            sum += longint'(coef_mem[k]) * longint'(basis_mem[p*64 + k]);
        end
        sum = ((sum + 64'sd8192) >>> 14) + 64'sd128;
        if (sum < 0) return 8'd0;
        if (sum > 255) return 8'd255;
        return 8'(sum);
    endfunction

    // Expected edge index of each strobe, counted from the Start-sampling edge.
    task automatic push_block(input int start_edge);
        exp_t e;
        for (int p = 0; p < 64; p++) begin
            e.addr    = 6'(p);
            e.data    = model_pix(p);
            e.at_edge = start_edge + 257 * (p + 1) - 1;
            sb.push_back(e);
        end
        rq.push_back(start_edge + 16448);
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (Read_Enable) re_cnt++;
        if (Pixel_Valid) begin
            chk("pix_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("pixel addr=%0d data=%0d edge=%0d", Pixel_Addr, Pixel_Data, edge_cnt);
                chk("pix_addr", 64'(Pixel_Addr), 64'(e.addr));
                chk("pix_data", 64'(Pixel_Data), 64'(e.data));
                chk("pix_cycle", 64'(edge_cnt), 64'(e.at_edge));
            end
        end
        if (Ready) begin
            chk("ready_pending", 64'(rq.size() > 0), 64'd1);
            if (rq.size() > 0) chk("ready_cycle", 64'(edge_cnt), 64'(rq.pop_front()));
        end
    end

    task automatic wait_edge(input int target);
        while (edge_cnt < target) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic start_block(input bit hold);
        @(posedge Clock);
        #1;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        s = edge_cnt;
        if (!hold) Start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_re"},     64'(Read_Enable), 64'd0);
        chk({tag, "_pv"},     64'(Pixel_Valid), 64'd0);
        chk({tag, "_busy"},   64'(Busy),        64'd0);
        chk({tag, "_ready"},  64'(Ready),       64'd0);
        chk({tag, "_caddr"},  64'(Coef_Addr),   64'd0);
        chk({tag, "_baddr"},  64'(Basis_Addr),  64'd0);
        chk({tag, "_paddr"},  64'(Pixel_Addr),  64'd0);
        chk({tag, "_pdata"},  64'(Pixel_Data),  64'd0);
    endtask

    task automatic check_block_end(input string tag);
        chk({tag, "_re_count"}, 64'(re_cnt), 64'd4096);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        for (int k = 0; k < 64; k++) coef_mem[k] = 12'sd0;
        coef_mem[0] = 12'sd64;
        for (int i = 0; i < 4096; i++) begin
            basis_mem[i] = (i % 64 == 0) ? 16'sd2048
                                         : 16'(int'($urandom_range(0, 8191)) - 4096);
        end

        // Reset, then idle
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        check_quiet("reset");

        // DC block with Start held high: second block (saturating high) follows
        re_cnt = 0;
        start_block(1'b1);
        push_block(s);
        wait_edge(s + 1000);
        chk("busy_mid", 64'(Busy), 64'd1);
        wait_edge(s + 16449);
        check_block_end("dc");
        chk("dc_ready_done", 64'(rq.size()), 64'd0);
        coef_mem[0] = 12'sd2047;
        push_block(s + 16450);
        re_cnt = 0;
        wait_edge(s + 16450);
        Start = 1'b0;
        s = s + 16450;
        wait_edge(s + 16449);
        check_block_end("sat_hi");
        chk("sat_hi_busy", 64'(Busy), 64'd0);

        // Saturating low block with a stray Start while busy
        coef_mem[0] = -12'sd2048;
        re_cnt = 0;
        start_block(1'b0);
        push_block(s);
        wait_edge(s + 5000);
        Start = 1'b1;
        wait_edge(s + 5001);
        Start = 1'b0;
        wait_edge(s + 16449);
        check_block_end("sat_lo");
        wait_edge(s + 16460);
        chk("sat_lo_idle", 64'(Busy), 64'd0);

        // Reset in the cycle after pixel 10
        coef_mem[0] = 12'sd64;
        start_block(1'b0);
        push_block(s);
        wait_edge(s + 257 * 11);
        chk("abort_pix_left", 64'(sb.size()), 64'd53);
        Reset = 1'b1;
        sb.delete();
        rq.delete();
        @(posedge Clock);
        #1;
        check_quiet("abort");
        Reset = 1'b0;
        repeat (300) @(posedge Clock);
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);

        // Mixed-content block after the abort
        for (int k = 0; k < 64; k++) coef_mem[k] = 12'sd0;
        for (int k = 0; k < 10; k++) begin
            coef_mem[$urandom_range(0, 63)] = 12'(int'($urandom_range(0, 80)) - 40);
        end
        re_cnt = 0;
        start_block(1'b0);
        push_block(s);
        wait_edge(s + 16449);
        check_block_end("mixed");
        chk("mixed_ready_done", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
